// File: rtl/v74x148_pkg.sv
// -----------------------------------------------------------------------------
// v74x148_pkg
//   Shared definitions for the latched 74x148-style priority encoder.
//   Contents:
//     DEFAULT_N   : default number of request lines.
//     MAX_N/MAX_W : widest vector the priority helper accepts.
//     state_t     : FSM encoding (ST_IDLE = 1'b0, ST_PRESENT = 1'b1).
//     prio_index  : index of the highest set bit of a zero-extended vector.
// -----------------------------------------------------------------------------
package v74x148_pkg;

  localparam int DEFAULT_N = 8;
  localparam int MAX_N     = 64;
  localparam int MAX_W     = 6;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  // Callers zero-extend their N-bit vector to MAX_N and cast the result
  // down to their own index width. Bit MAX_N-1 has the highest priority.
  function automatic logic [MAX_W-1:0] prio_index(input logic [MAX_N-1:0] vec);
    logic [MAX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (vec[i]) begin
        idx = i[MAX_W-1:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/v74x148_latched_encoder_if.sv
// -----------------------------------------------------------------------------
// v74x148_latched_encoder_if
//   Request/present/acknowledge bundle of the latched encoder.
//   Signals:
//     EI_L  : enable in, active-low.
//     I_L   : N request lines, active-low, falling edge = event.
//     ACK   : consumer acknowledge of the presented index.
//     A_L   : presented index, active-low.
//     GS_L  : low while an index is presented.
//     EO_L  : low when enabled with nothing pending and nothing presented.
//   Modports:
//     master : request source / consumer side (drives EI_L, I_L, ACK).
//     slave  : encoder side (drives A_L, GS_L, EO_L).
// -----------------------------------------------------------------------------
interface v74x148_latched_encoder_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic         EI_L;
  logic [N-1:0] I_L;
  logic         ACK;
  logic [W-1:0] A_L;
  logic         GS_L;
  logic         EO_L;

  modport master (output EI_L, I_L, ACK, input A_L, GS_L, EO_L);
  modport slave  (input EI_L, I_L, ACK, output A_L, GS_L, EO_L);

endinterface

// File: rtl/v74x148_edge_capture.sv
// -----------------------------------------------------------------------------
// v74x148_edge_capture
//   Detects high-to-low transitions on the active-low request lines.
//   Ports:
//     clk  : rising-edge clock.
//     rst  : asynchronous active-high reset.
//     i_l  : N request lines, active-low.
//     rise : one bit per line, high in the cycle its falling edge is seen.
//   Build option V74X148_SYNC_EN inserts a 2-flop synchronizer per line
//   (reset to all ones) ahead of the edge detector, for asynchronous I_L.
// -----------------------------------------------------------------------------
module v74x148_edge_capture #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_l,
  output logic [N-1:0] rise
);

  logic [N-1:0] sample_s;
  logic [N-1:0] i_q_r;

`ifdef V74X148_SYNC_EN
  logic [N-1:0] sync1_r;
  logic [N-1:0] sync2_r;

  // Two-stage synchronizer; idles high so reset never fakes an event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= '1;
      sync2_r <= '1;
    end else begin
      sync1_r <= i_l;
      sync2_r <= sync1_r;
    end
  end

  assign sample_s = sync2_r;
`else
  assign sample_s = i_l;
`endif

  // Previous sample; resetting to ones makes a line held low through
  // reset release count as exactly one event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q_r <= '1;
    end else begin
      i_q_r <= sample_s;
    end
  end

  assign rise = i_q_r & ~sample_s;

endmodule

// File: rtl/v74x148_latched_encoder.sv
// -----------------------------------------------------------------------------
// v74x148_latched_encoder
//   Latches falling-edge events on N active-low request lines and presents
//   the highest pending index, 74x148 style, held under a present/ack
//   handshake.
//   Ports:
//     CLK   : rising-edge clock.
//     RESET : asynchronous active-high reset.
//     bus   : v74x148_latched_encoder_if.slave (EI_L, I_L, ACK in;
//             A_L, GS_L, EO_L out, all outputs registered).
//   Build option V74X148_SYNC_EN (in v74x148_edge_capture) adds a 2-cycle
//   input synchronizer.
// -----------------------------------------------------------------------------
module v74x148_latched_encoder
  import v74x148_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic                          CLK,
  input  logic                          RESET,
  v74x148_latched_encoder_if.slave      bus
);

  localparam int W = $clog2(N);

  state_t           state_r;
  state_t           state_s;
  logic [N-1:0]     pending_r;
  logic [N-1:0]     pending_s;
  logic [N-1:0]     rise_s;
  logic [N-1:0]     set_s;
  logic [N-1:0]     clr_s;
  logic [MAX_N-1:0] pend_ext_s;
  logic [W-1:0]     top_s;
  logic [W-1:0]     idx_r;
  logic [W-1:0]     idx_s;
  logic [W-1:0]     a_l_r;
  logic [W-1:0]     a_l_s;
  logic             gs_l_r;
  logic             gs_l_s;
  logic             eo_l_r;
  logic             eo_l_s;

  v74x148_edge_capture #(.N(N)) u_edge_capture (
    .clk  (CLK),
    .rst  (RESET),
    .i_l  (bus.I_L),
    .rise (rise_s)
  );

  // Highest-priority pending bit, evaluated on the current pending set.
  always_comb begin
    pend_ext_s          = '0;
    pend_ext_s[N-1:0]   = pending_r;
    top_s               = W'(prio_index(pend_ext_s));
  end

  // Next-state, pending update and next registered outputs.
  always_comb begin
    set_s   = bus.EI_L ? '0 : rise_s;
    clr_s   = '0;
    state_s = state_r;
    idx_s   = idx_r;
    a_l_s   = a_l_r;
    gs_l_s  = gs_l_r;
    case (state_r)
      ST_IDLE: begin
        if (!bus.EI_L && (pending_r != '0)) begin
          state_s = ST_PRESENT;
          idx_s   = top_s;
          a_l_s   = ~top_s;
          gs_l_s  = 1'b0;
        end else begin
          a_l_s   = '1;
          gs_l_s  = 1'b1;
        end
      end
      ST_PRESENT: begin
        // Acknowledge wins over a simultaneous disable: the index was
        // already handed to the consumer.
        if (bus.ACK) begin
          state_s = ST_IDLE;
          clr_s   = {{(N-1){1'b0}}, 1'b1} << idx_r;
          a_l_s   = '1;
          gs_l_s  = 1'b1;
        end else if (bus.EI_L) begin
          state_s = ST_IDLE;
          a_l_s   = '1;
          gs_l_s  = 1'b1;
        end else begin
          state_s = ST_PRESENT;
        end
      end
      default: begin
        state_s = ST_IDLE;
        a_l_s   = '1;
        gs_l_s  = 1'b1;
      end
    endcase
    // Set after clear so a new event on the acknowledged bit survives.
    pending_s = (pending_r & ~clr_s) | set_s;
    eo_l_s    = ~(!bus.EI_L && (pending_s == '0) && (state_s == ST_IDLE));
  end

  // State, pending set and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r   <= ST_IDLE;
      pending_r <= '0;
      idx_r     <= '0;
      a_l_r     <= '1;
      gs_l_r    <= 1'b1;
      eo_l_r    <= 1'b1;
    end else begin
      state_r   <= state_s;
      pending_r <= pending_s;
      idx_r     <= idx_s;
      a_l_r     <= a_l_s;
      gs_l_r    <= gs_l_s;
      eo_l_r    <= eo_l_s;
    end
  end

  assign bus.A_L  = a_l_r;
  assign bus.GS_L = gs_l_r;
  assign bus.EO_L = eo_l_r;

endmodule

// File: tb/tb_v74x148_latched_encoder.sv
// -----------------------------------------------------------------------------
// tb_v74x148_latched_encoder
//   Scoreboard bench: each stimulus cycle runs a rule-level reference model
//   and queues the expected outputs for the coming clock edge; a monitor
//   pops and compares after every rising edge.
// -----------------------------------------------------------------------------
module tb_v74x148_latched_encoder;
  import v74x148_pkg::*;

  localparam int N = 8;
  localparam int W = 3;

  typedef struct packed {
    logic [W-1:0] a_l;
    logic         gs_l;
    logic         eo_l;
  } exp_t;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  v74x148_latched_encoder_if #(.N(N)) bus ();

  v74x148_latched_encoder #(.N(N)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: pending set of indices, a "presenting" flag and the
  // index being shown, advanced once per clock edge.
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_prev = '1;
  logic [N-1:0] m_s1   = '1;
  logic [N-1:0] m_s2   = '1;
  bit           m_busy = 1'b0;
  int           m_idx  = 0;

  function automatic exp_t model_edge(input logic ei, input logic [N-1:0] il,
                                      input logic ack, input logic rst);
    exp_t         o;
    logic [N-1:0] seen;
    logic [N-1:0] ev;
    logic [W-1:0] idx_bits;
    if (rst) begin
      m_pend = '0; m_prev = '1; m_s1 = '1; m_s2 = '1; m_busy = 1'b0;
      o.a_l = '1; o.gs_l = 1'b1; o.eo_l = 1'b1;
      return o;
    end
`ifdef V74X148_SYNC_EN
    seen = m_s2; m_s2 = m_s1; m_s1 = il;
`else
    seen = il;
`endif
    ev = '0;
    for (int i = 0; i < N; i++)
      if (m_prev[i] && !seen[i] && !ei) ev[i] = 1'b1;
    if (m_busy) begin
      if (ack) begin
        m_pend[m_idx] = 1'b0;
        m_busy = 1'b0;
      end else if (ei) begin
        m_busy = 1'b0;
      end
    end else if (!ei && m_pend != '0) begin
      for (int i = 0; i < N; i++) if (m_pend[i]) m_idx = i;
      m_busy = 1'b1;
    end
    m_pend = m_pend | ev;
    m_prev = seen;
    idx_bits = m_idx[W-1:0];
    o.a_l  = m_busy ? ~idx_bits : '1;
    o.gs_l = !m_busy;
    o.eo_l = !(!ei && m_pend == '0 && !m_busy);
    return o;
  endfunction

  // One stimulus cycle: drive at the falling edge, queue the expectation.
  task automatic cyc(input logic ei, input logic [N-1:0] il,
                     input logic ack, input logic rst);
    exp_t e;
    @(negedge CLK);
    RESET    = rst;
    bus.EI_L = ei;
    bus.I_L  = il;
    bus.ACK  = ack;
    e = model_edge(ei, il, ack, rst);
    exp_q.push_back(e);
    if (rst) begin
      #1;
      n_cmp++;
      if ({bus.A_L, bus.GS_L, bus.EO_L} !== {3'b111, 1'b1, 1'b1}) begin
        n_err++;
        $display("FAIL async_reset: got A_L=%b GS_L=%b EO_L=%b, expected A_L=111 GS_L=1 EO_L=1",
                 bus.A_L, bus.GS_L, bus.EO_L);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'hFF, 1'b0, 1'b0);
  endtask

  // Monitor: compare registered outputs just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus.A_L, bus.GS_L, bus.EO_L} !== e) begin
          n_err++;
          $display("FAIL outputs @%0t: got A_L=%b GS_L=%b EO_L=%b, expected A_L=%b GS_L=%b EO_L=%b",
                   $time, bus.A_L, bus.GS_L, bus.EO_L, e.a_l, e.gs_l, e.eo_l);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] il_r;
    logic [N-1:0] flip;
    bus.EI_L = 1'b0;
    bus.I_L  = 8'hFF;
    bus.ACK  = 1'b0;

    cyc(1'b0, 8'hFF, 1'b0, 1'b1);
    cyc(1'b0, 8'hFF, 1'b0, 1'b1);
    idle(3);

    // Single event on bit 5, acknowledged a few cycles later.
    cyc(1'b0, 8'hDF, 1'b0, 1'b0);
    idle(2);
    cyc(1'b0, 8'hFF, 1'b1, 1'b0);
    idle(4);

    // Bits 6 and 2 together: 6 first, then 2 after the gap.
    cyc(1'b0, 8'hBB, 1'b0, 1'b0);
    idle(3);
    cyc(1'b0, 8'hFF, 1'b1, 1'b0);
    idle(3);
    cyc(1'b0, 8'hFF, 1'b1, 1'b0);
    idle(4);

    // Bit 1 presented, bit 7 arrives while held.
    cyc(1'b0, 8'hFD, 1'b0, 1'b0);
    idle(3);
    cyc(1'b0, 8'h7F, 1'b0, 1'b0);
    idle(2);
    cyc(1'b0, 8'hFF, 1'b1, 1'b0);
    idle(3);
    cyc(1'b0, 8'hFF, 1'b1, 1'b0);
    idle(4);

    // Bit 3 acknowledged in the same cycle as a fresh bit 3 event.
    cyc(1'b0, 8'hF7, 1'b0, 1'b0);
    idle(4);
    cyc(1'b0, 8'hF7, 1'b1, 1'b0);
    idle(3);
    // Disable while presenting, then re-enable.
    cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    idle(3);
    cyc(1'b0, 8'hFF, 1'b1, 1'b0);
    idle(4);

    // Reset mid-presentation with bits 7 and 0 pending.
    cyc(1'b0, 8'h7E, 1'b0, 1'b0);
    idle(4);
    cyc(1'b0, 8'hFF, 1'b0, 1'b1);
    cyc(1'b0, 8'hFF, 1'b0, 1'b1);
    idle(6);

    // Randomized traffic with occasional disables, acks and resets.
    il_r = 8'hFF;
    for (int c = 0; c < 3000; c++) begin
      flip = '0;
      for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 5) == 0);
      il_r = il_r ^ flip;
      cyc(($urandom_range(0, 19) == 0), il_r,
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 299) == 0));
    end
    idle(2);

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge CLK);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d entries left in queue, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
